// File: rtl/rgbw_pkg.sv
// Shared constants and helpers for the RGBW PWM driver.
// Channel indices, phase stagger step and the full-scale duty code.
package rgbw_pkg;

   typedef logic [7:0] duty_t;

   localparam int unsigned NUM_CH = 4;
   localparam int unsigned CH_R   = 0;
   localparam int unsigned CH_G   = 1;
   localparam int unsigned CH_B   = 2;
   localparam int unsigned CH_W   = 3;

   localparam logic [7:0] PHASE_STEP = 8'd64;
   localparam logic [7:0] DUTY_FULL  = 8'hFF;
   localparam logic [7:0] CNT_LAST   = 8'hFF;

   // Phase offset of channel ch; zero for every channel when stagger is off.
   function automatic logic [7:0] ch_offset(input int unsigned ch, input bit stagger);
      logic [7:0] w_off;
      w_off = 8'(ch) * PHASE_STEP;
      return stagger ? w_off : 8'd0;
   endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: double-buffered duty, phase-offset compare and registered pin.
// The shadow only changes on the period wrap tick or while the driver is disabled.
module pwm_channel
   import rgbw_pkg::*;
#(
   parameter logic [7:0] OFFSET = 8'd0
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_en,
   input  logic       i_tick,
   input  logic       i_load,
   input  logic [7:0] i_pwm_cnt,
   input  duty_t      i_duty,
   output logic       o_pwm
);

   duty_t      r_shadow;
   logic       r_out;
   logic [7:0] w_phase;
   logic       w_high;
   logic       w_take;

   always_comb begin
      w_phase = i_pwm_cnt + OFFSET;
      // Full scale must not drop for one count at phase 255.
      w_high  = (r_shadow == DUTY_FULL) || (w_phase < r_shadow);
      w_take  = !i_en || (i_tick && i_load);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_shadow <= '0;
         r_out    <= 1'b0;
      end else begin
         if (w_take) begin
            r_shadow <= i_duty;
         end
         r_out <= i_en && w_high;
      end
   end

   assign o_pwm = r_out;

endmodule

// File: rtl/rgbw_pwm_driver.sv
// Four-channel RGBW LED PWM driver with period-synchronous duty update.
// Holds the prescaler, the shared 8-bit period counter and the load pulse.
module rgbw_pwm_driver
   import rgbw_pkg::*;
#(
   parameter int unsigned CLK_DIV = 4,
   parameter bit          STAGGER = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       en,
   input  logic [7:0] redIn,
   input  logic [7:0] greenIn,
   input  logic [7:0] blueIn,
   input  logic [7:0] whiteIn,
   output logic [3:0] pwmOut,
   output logic       periodStart
);

   localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

   logic [7:0] r_div_cnt;
   logic [7:0] r_pwm_cnt;
   logic       r_period_start;

   logic       w_tick;
   logic       w_wrap;
   logic       w_load;
   duty_t      w_duty [NUM_CH];
   logic [3:0] w_pwm;

   always_comb begin
      w_tick = (r_div_cnt == DIV_LAST);
      w_wrap = (r_pwm_cnt == CNT_LAST);
      w_load = en && w_tick && w_wrap;
   end

   assign w_duty[CH_R] = redIn;
   assign w_duty[CH_G] = greenIn;
   assign w_duty[CH_B] = blueIn;
   assign w_duty[CH_W] = whiteIn;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_div_cnt      <= '0;
         r_pwm_cnt      <= '0;
         r_period_start <= 1'b0;
      end else if (!en) begin
         r_div_cnt      <= '0;
         r_pwm_cnt      <= '0;
         r_period_start <= 1'b0;
      end else begin
         r_div_cnt      <= w_tick ? 8'd0 : r_div_cnt + 8'd1;
         if (w_tick) begin
            r_pwm_cnt <= r_pwm_cnt + 8'd1;
         end
         // Aligned with the cycle in which the new shadows become visible.
         r_period_start <= w_load;
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      pwm_channel #(
         .OFFSET (ch_offset(g, STAGGER))
      ) u_ch (
         .i_clk     (clk),
         .i_rst_n   (reset),
         .i_en      (en),
         .i_tick    (w_tick),
         .i_load    (w_wrap),
         .i_pwm_cnt (r_pwm_cnt),
         .i_duty    (w_duty[g]),
         .o_pwm     (w_pwm[g])
      );
   end

   assign pwmOut      = w_pwm;
   assign periodStart = r_period_start;

endmodule

// File: tb/tb_rgbw_pwm_driver.sv
// Bench for rgbw_pwm_driver: three configurations, per-period high-time scoreboard.
// Each periodStart closes a measurement window that is compared against a queued entry.
module tb_rgbw_pwm_driver;

   logic       clk = 1'b0;
   logic       reset;
   logic       en;
   logic [7:0] a_r, a_g, a_b, a_w;
   logic [7:0] b_d;
   logic [7:0] c_w;
   logic [3:0] out_a, out_b, out_c;
   logic       ps_a, ps_b, ps_c;

   int total = 0;
   int bad   = 0;

   typedef struct {
      int c0;
      int c1;
      int c2;
      int c3;
      int len;
   } exp_t;

   exp_t qa[$];
   exp_t qb[$];
   exp_t qc[$];

   always #5 clk = ~clk;

   rgbw_pwm_driver #(.CLK_DIV(1), .STAGGER(1'b0)) u_dut_a (
      .clk(clk), .reset(reset), .en(en),
      .redIn(a_r), .greenIn(a_g), .blueIn(a_b), .whiteIn(a_w),
      .pwmOut(out_a), .periodStart(ps_a)
   );

   rgbw_pwm_driver #(.CLK_DIV(1), .STAGGER(1'b1)) u_dut_b (
      .clk(clk), .reset(reset), .en(en),
      .redIn(b_d), .greenIn(b_d), .blueIn(b_d), .whiteIn(b_d),
      .pwmOut(out_b), .periodStart(ps_b)
   );

   rgbw_pwm_driver #(.CLK_DIV(4), .STAGGER(1'b0)) u_dut_c (
      .clk(clk), .reset(reset), .en(en),
      .redIn(8'd0), .greenIn(8'd0), .blueIn(8'd0), .whiteIn(c_w),
      .pwmOut(out_c), .periodStart(ps_c)
   );

   task automatic chk(input string tag, input int got, input int exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   function automatic exp_t mk(input int c0, input int c1, input int c2, input int c3,
                               input int len);
      exp_t e;
      e.c0 = c0; e.c1 = c1; e.c2 = c2; e.c3 = c3; e.len = len;
      return e;
   endfunction

   // Window monitors: accumulate per-pin high samples, close on periodStart.
   int   a_acc [4];
   int   a_len;
   exp_t ea;
   always @(negedge clk) begin
      if (!reset || !en) begin
         a_len = 0;
         for (int i = 0; i < 4; i++) a_acc[i] = 0;
      end else begin
         a_len++;
         for (int i = 0; i < 4; i++) a_acc[i] += int'(out_a[i]);
         if (ps_a) begin
            chk("a_sb_depth", int'(qa.size() > 0), 1);
            if (qa.size() > 0) begin
               ea = qa.pop_front();
               chk("a_red_high", a_acc[0], ea.c0);
               chk("a_green_high", a_acc[1], ea.c1);
               chk("a_blue_high", a_acc[2], ea.c2);
               chk("a_white_high", a_acc[3], ea.c3);
               chk("a_period_len", a_len, ea.len);
            end
            a_len = 0;
            for (int i = 0; i < 4; i++) a_acc[i] = 0;
         end
      end
   end

   int   b_acc [4];
   int   b_len, b_ovl, b_gap;
   exp_t eb;
   always @(negedge clk) begin
      if (!reset || !en) begin
         b_len = 0; b_ovl = 0; b_gap = 0;
         for (int i = 0; i < 4; i++) b_acc[i] = 0;
      end else begin
         b_len++;
         for (int i = 0; i < 4; i++) b_acc[i] += int'(out_b[i]);
         if ($countones(out_b) > 1) b_ovl++;
         if (out_b == 4'b0000) b_gap++;
         if (ps_b) begin
            chk("b_sb_depth", int'(qb.size() > 0), 1);
            if (qb.size() > 0) begin
               eb = qb.pop_front();
               chk("b_red_high", b_acc[0], eb.c0);
               chk("b_green_high", b_acc[1], eb.c1);
               chk("b_blue_high", b_acc[2], eb.c2);
               chk("b_white_high", b_acc[3], eb.c3);
               chk("b_period_len", b_len, eb.len);
               chk("b_overlap_samples", b_ovl, 0);
               chk("b_gap_samples", b_gap, 0);
            end
            b_len = 0; b_ovl = 0; b_gap = 0;
            for (int i = 0; i < 4; i++) b_acc[i] = 0;
         end
      end
   end

   int   c_acc [4];
   int   c_len;
   exp_t ec;
   always @(negedge clk) begin
      if (!reset || !en) begin
         c_len = 0;
         for (int i = 0; i < 4; i++) c_acc[i] = 0;
      end else begin
         c_len++;
         for (int i = 0; i < 4; i++) c_acc[i] += int'(out_c[i]);
         if (ps_c) begin
            chk("c_sb_depth", int'(qc.size() > 0), 1);
            if (qc.size() > 0) begin
               ec = qc.pop_front();
               chk("c_red_high", c_acc[0], ec.c0);
               chk("c_white_high", c_acc[3], ec.c3);
               chk("c_period_len", c_len, ec.len);
            end
            c_len = 0;
            for (int i = 0; i < 4; i++) c_acc[i] = 0;
         end
      end
   end

   initial begin
      a_r = 8'd64; a_g = 8'd0; a_b = 8'd255; a_w = 8'd0;
      b_d = 8'd64; c_w = 8'd10;
      reset = 1'b0; en = 1'b0;
      cyc(3);
      chk("rst_out_a", int'(out_a), 0);
      chk("rst_ps_a", int'(ps_a), 0);
      chk("rst_out_b", int'(out_b), 0);
      chk("rst_out_c", int'(out_c), 0);
      chk("rst_ps_c", int'(ps_c), 0);

      reset = 1'b1;
      cyc(2);
      chk("dis_out_a", int'(out_a), 0);

      // First enabled period uses current inputs without a load pulse.
      qa.push_back(mk(64, 0, 256, 0, 256));
      qa.push_back(mk(64, 0, 256, 0, 256));
      repeat (4) qb.push_back(mk(64, 64, 64, 64, 256));
      qc.push_back(mk(0, 0, 0, 40, 1024));
      en = 1'b1;
      cyc(256);
      chk("wrap_ps_a", int'(ps_a), 1);
      chk("wrap_red_low", int'(out_a[0]), 0);
      chk("wrap_ps_b", int'(ps_b), 1);
      cyc(1);
      chk("post_wrap_red_rise", int'(out_a[0]), 1);
      chk("post_wrap_ps_a", int'(ps_a), 0);

      // Mid-period input change at pwm_cnt=100 must wait for the next wrap.
      cyc(99);
      a_r = 8'd192;
      qa.push_back(mk(192, 0, 256, 0, 256));
      qa.push_back(mk(192, 0, 256, 0, 256));
      cyc(668);
      chk("seg1_qa_empty", qa.size(), 0);
      chk("seg1_qb_empty", qb.size(), 0);
      chk("seg1_qc_empty", qc.size(), 0);

      a_r = 8'd128;
      qa.push_back(mk(192, 0, 256, 0, 256));
      qb.push_back(mk(64, 64, 64, 64, 256));
      cyc(256);
      chk("seg2_qa_empty", qa.size(), 0);

      // Now at pwm_cnt=30 of a duty-128 period.
      cyc(30);
      chk("pre_rst_red", int'(out_a[0]), 1);
      reset = 1'b0;
      #1;
      chk("async_rst_out_a", int'(out_a), 0);
      chk("async_rst_out_b", int'(out_b), 0);
      chk("async_rst_out_c", int'(out_c), 0);
      chk("async_rst_ps_a", int'(ps_a), 0);

      en = 1'b0;
      cyc(2);
      reset = 1'b1;
      cyc(2);
      chk("rel_out_a", int'(out_a), 0);

      qa.push_back(mk(128, 0, 256, 0, 256));
      qb.push_back(mk(64, 64, 64, 64, 256));
      en = 1'b1;
      cyc(1);
      chk("restart_out_a", int'(out_a), 5);
      chk("restart_out_b", int'(out_b), 1);
      chk("restart_ps_a", int'(ps_a), 0);
      cyc(255);
      chk("seg3_qa_empty", qa.size(), 0);
      cyc(10);
      chk("pre_dis_red", int'(out_a[0]), 1);

      en = 1'b0;
      cyc(1);
      chk("en_low_out_a", int'(out_a), 0);
      chk("en_low_out_b", int'(out_b), 0);
      chk("en_low_out_c", int'(out_c), 0);
      chk("en_low_ps_a", int'(ps_a), 0);

      // Re-enable: pwm_cnt restarts at 0, so each window is a full period.
      repeat (4) qa.push_back(mk(128, 0, 256, 0, 256));
      repeat (4) qb.push_back(mk(64, 64, 64, 64, 256));
      qc.push_back(mk(0, 0, 0, 40, 1024));
      en = 1'b1;
      cyc(1024);
      chk("end_qa_empty", qa.size(), 0);
      chk("end_qb_empty", qb.size(), 0);
      chk("end_qc_empty", qc.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
